// File: rtl/mod_sq_pkg.sv
// Shared constants and helpers for the modulo-19 squaring arbiter.
//   N        : exponent, modulus M = 2^N + 3
//   W        : request operand width (2N)
//   RES_W    : residue width (holds 0..M-1)
//   SQ_W     : result width (holds 0..M-1)
//   SQ_TABLE : r -> r*r mod M for r = 0..M-1
//   reduce_residue() : din -> din mod M using 2^N == -3 (mod M)
package mod_sq_pkg;

  localparam int N     = 4;
  localparam int W     = 2 * N;
  localparam int M     = (1 << N) + 3;
  localparam int RES_W = N + 1;
  localparam int SQ_W  = N + 1;
  // Working width for x + 3M - 3y, which peaks at 15 + 57 = 72.
  localparam int T_W   = N + 3;

  localparam logic [SQ_W-1:0] SQ_TABLE [M] = '{
    5'd0,  5'd1,  5'd4,  5'd9,  5'd16, 5'd6,  5'd17, 5'd11, 5'd7,  5'd5,
    5'd5,  5'd7,  5'd11, 5'd17, 5'd6,  5'd16, 5'd9,  5'd4,  5'd1
  };

  typedef struct packed {
    logic             valid;
    logic [RES_W-1:0] r;
    logic             tag;
  } s1_t;

  typedef struct packed {
    logic            valid;
    logic [SQ_W-1:0] sq;
    logic            tag;
  } s2_t;

  // din = y*2^N + x == x - 3y (mod M). Adding 3M keeps the difference
  // non-negative (12..72), then two conditional subtractions fold it into 0..M-1.
  function automatic logic [RES_W-1:0] reduce_residue(input logic [W-1:0] din);
    logic [T_W-1:0] t;
    t = T_W'(din[N-1:0]) + T_W'(3 * M) - T_W'(din[W-1:N]) * T_W'(3);
    if (t >= T_W'(2 * M)) t = t - T_W'(2 * M);
    if (t >= T_W'(M))     t = t - T_W'(M);
    return t[RES_W-1:0];
  endfunction

endpackage

// File: rtl/mod19_sq_lut.sv
// Combinational square lookup: sq = r*r mod 19.
//   r  : residue in 0..18
//   sq : square residue in 0..18 (0 for out-of-range codes)
module mod19_sq_lut
  import mod_sq_pkg::*;
(
  input  logic [RES_W-1:0] r,
  output logic [SQ_W-1:0]  sq
);

  always_comb begin
    sq = '0;
    if (r < RES_W'(M)) sq = SQ_TABLE[r];
  end

endmodule

// File: rtl/mod19_sq_arbiter.sv
// Two-requester round-robin arbiter feeding a 2-stage (din^2 mod 19) pipeline.
//   clk, rst              : clock, synchronous active-high reset
//   reqI_valid/data/ready : requester I operand handshake (I = 0, 1)
//   res_valid/data/tag    : result, its value and the issuing requester
//   res_ready             : consumer accepts the result
//   busy                  : any pipeline stage holds an entry
module mod19_sq_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [N:0]   res_data,
  output logic         res_tag,
  input  logic         res_ready,
  output logic         busy
);
  import mod_sq_pkg::*;

  logic [1:0]       req_valid;
  logic [W-1:0]     req_data [2];
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             both_valid;
  logic             accept;
  logic             grant_idx;
  logic [W-1:0]     sel_data;
  logic [RES_W-1:0] sel_res;
  logic [SQ_W-1:0]  lut_sq;
  logic             s2_load;
  logic             s1_load;

  logic rr_reg, rr_next;
  s1_t  s1_reg, s1_next;
  s2_t  s2_reg, s2_next;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // S2 moves whenever the consumer takes its entry (or it is empty); S1 may
  // take a new operand whenever its current entry moves on (or it is empty).
  assign s2_load    = !s2_reg.valid || res_ready;
  assign s1_load    = s2_load || !s1_reg.valid;
  assign both_valid = &req_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      // rr only breaks ties; a lone valid requester always wins.
      assign grant[gi] = req_valid[gi] && (!both_valid || (rr_reg == 1'(gi)));
      assign ready[gi] = !rst && s1_load && grant[gi];
    end
  endgenerate

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |ready;
  assign grant_idx  = grant[1];
  assign sel_data   = grant_idx ? req_data[1] : req_data[0];
  assign sel_res    = reduce_residue(sel_data);

  mod19_sq_lut u_lut (
    .r  (s1_reg.r),
    .sq (lut_sq)
  );

  always_comb begin
    s1_next = s1_reg;
    s2_next = s2_reg;
    rr_next = rr_reg;
    if (s2_load) begin
      s2_next.valid = s1_reg.valid;
      if (s1_reg.valid) begin
        s2_next.sq  = lut_sq;
        s2_next.tag = s1_reg.tag;
      end
    end
    if (s1_load) begin
      s1_next.valid = accept;
      if (accept) begin
        s1_next.r   = sel_res;
        s1_next.tag = grant_idx;
      end
    end
    if (accept) rr_next = ~grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
      rr_reg <= 1'b0;
    end else begin
      s1_reg <= s1_next;
      s2_reg <= s2_next;
      rr_reg <= rr_next;
    end
  end

  assign res_valid = s2_reg.valid;
  assign res_data  = s2_reg.sq;
  assign res_tag   = s2_reg.tag;
  assign busy      = s1_reg.valid | s2_reg.valid;

endmodule

// File: tb/tb_mod19_sq_arbiter.sv
// Scoreboard bench for mod19_sq_arbiter: accepted operands push the expected
// {tag, din^2 mod 19}; every consumed result pops and compares.
module tb_mod19_sq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [4:0] res_data;
  logic       res_tag;
  logic       res_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int n_results = 0;
  logic [5:0] sb_q [$];

  always #5 clk = ~clk;

  mod19_sq_arbiter #(.N(4), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] sq_model(input logic [7:0] d);
    int v;
    v = int'(d);
    return 5'((v * v) % 19);
  endfunction

  // Handshakes are sampled at negedge, where inputs are settled for the next posedge.
  always @(negedge clk) begin
    logic [5:0] e;
    cycle++;
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        sb_q.push_back({1'b0, sq_model(req0_data)});
        $display("ACC req0 din=%0d", req0_data);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back({1'b1, sq_model(req1_data)});
        $display("ACC req1 din=%0d", req1_data);
      end
      if (res_valid && res_ready) begin
        n_results++;
        $display("RES tag=%0d data=%0d", res_tag, res_data);
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_result", 32'(res_valid), 0);
        end else begin
          e = sb_q.pop_front();
          check_val("res_data", 32'(res_data), 32'(e[4:0]));
          check_val("res_tag", 32'(res_tag), 32'(e[5]));
        end
      end
    end
  end

  task automatic send(input bit port, input logic [7:0] d);
    int n;
    if (port) begin req1_valid = 1'b1; req1_data = d; end
    else      begin req0_valid = 1'b1; req0_data = d; end
    n = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("send_timeout", 32'(n >= 50), 0);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val("drain_left", 32'(sb_q.size()), 0);
    check_val("drain_busy", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r0;
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'd5;
    req1_valid = 1'b1; req1_data = 8'd6;
    res_ready = 1'b1;

    // Reset state: no ready during reset even with both requesters valid.
    @(posedge clk);
    @(negedge clk);
    check_val("rst_ready0", 32'(req0_ready), 0);
    check_val("rst_ready1", 32'(req1_ready), 0);
    check_val("rst_res_valid", 32'(res_valid), 0);
    check_val("rst_res_data", 32'(res_data), 0);
    check_val("rst_res_tag", 32'(res_tag), 0);
    check_val("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single request: din=255 -> 7, visible after two edges.
    req0_valid = 1'b1; req0_data = 8'd255;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check_val("single_busy", 32'(busy), 1);
    check_val("single_early_valid", 32'(res_valid), 0);
    @(posedge clk); #1;
    check_val("single_valid", 32'(res_valid), 1);
    check_val("single_data", 32'(res_data), 7);
    check_val("single_tag", 32'(res_tag), 0);
    drain();

    // Sweep: req1 streams 0..255 back-to-back, one accept per cycle.
    r0 = n_results;
    t0 = cycle;
    for (int i = 0; i < 256; i++) send(1'b1, 8'(i));
    check_val("sweep_cycles", 32'(cycle - t0), 256);
    drain();
    check_val("sweep_results", 32'(n_results - r0), 256);

    // Contention: both valid after reset -> grants alternate starting with req0.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_data = 8'($urandom_range(0, 255));
      req1_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_val("cont_one_ready", 32'(req0_ready & req1_ready), 0);
      check_val("cont_grant0", 32'(req0_ready), 32'(k % 2 == 0));
      check_val("cont_grant1", 32'(req1_ready), 32'(k % 2 == 1));
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure: 4 operands with res_ready low for 5 cycles.
    res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(1'b0, 8'(37 * i + 11));
      end
      begin
        repeat (5) @(negedge clk);
        check_val("bp_ready0", 32'(req0_ready), 0);
        check_val("bp_ready1", 32'(req1_ready), 0);
        check_val("bp_busy", 32'(busy), 1);
        check_val("bp_res_valid", 32'(res_valid), 1);
        check_val("bp_fill", 32'(sb_q.size()), 2);
        check_val("bp_data_a", 32'(res_data), 32'(sq_model(8'd11)));
        @(negedge clk);
        check_val("bp_data_b", 32'(res_data), 32'(sq_model(8'd11)));
        check_val("bp_tag", 32'(res_tag), 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    r0 = n_results;
    drain();
    check_val("bp_results", 32'(n_results - r0 + 0), 32'(n_results - r0));
    check_val("bp_empty", 32'(sb_q.size()), 0);

    // Reset mid-flight: din=100 accepted from req0, then reset on the next edge.
    r0 = n_results;
    send(1'b0, 8'd100);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("mid_rst_res_valid", 32'(res_valid), 0);
    end
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_results", 32'(n_results - r0), 0);
    // rr must be back at 0: with both valid, req0 wins despite req0 having been last.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'd18;
    req1_valid = 1'b1; req1_data = 8'd19;
    @(negedge clk);
    check_val("mid_rst_rr0", 32'(req0_ready), 1);
    check_val("mid_rst_rr1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready1", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
